// File: rtl/button_conditioner.sv
// button_conditioner
//
// Conditions the raw ship-control push-buttons before they reach the game top level.
//   - Each raw button passes through a two-flop synchroniser and then a per-button debouncer.
//     A new level is accepted only after it has held for DEBOUNCE_CYCLES pclk cycles.
//   - Left/right movement levels are registered.
//     Pressing both at once cancels both outputs.
//   - A fire FSM turns each debounced press into a single-cycle fire_pulse.
//     After each pulse it enforces a cooldown of COOLDOWN_FRAMES frames.
//     A frame is counted on each rising edge of vsync_in.
//
// Optional feature, macro BUTTON_AUTOFIRE_EN:
//   - When the macro is defined and fire is still held at the end of a cooldown, the FSM
//     fires again. Each repeat cooldown lasts AUTOFIRE_FRAMES frames.
//   - When the macro is undefined, every press yields exactly one pulse.
//
// Ports:
//   pclk        in   pixel clock
//   rst         in   asynchronous active-low reset
//   left_in     in   raw left button (asynchronous)
//   right_in    in   raw right button (asynchronous)
//   fire_in     in   raw fire button (asynchronous)
//   vsync_in    in   vsync from the timing chain; rising edge = frame tick
//   left_out    out  debounced left level, registered
//   right_out   out  debounced right level, registered
//   fire_pulse  out  one-pclk missile request, registered
//   fire_ready  out  high while the fire FSM is idle (next press would fire)

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned AUTOFIRE_FRAMES = 15
) (
  input  logic pclk,
  input  logic rst,
  input  logic left_in,
  input  logic right_in,
  input  logic fire_in,
  input  logic vsync_in,
  output logic left_out,
  output logic right_out,
  output logic fire_pulse,
  output logic fire_ready
);

  // Button lanes: 0 = left, 1 = right, 2 = fire
  localparam int NumBtn = 3;
  localparam int BtnL   = 0;
  localparam int BtnR   = 1;
  localparam int BtnF   = 2;

  localparam int unsigned MaxFrames =
      (AUTOFIRE_FRAMES > COOLDOWN_FRAMES) ? AUTOFIRE_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned FRAME_W = (MaxFrames == 0) ? 1 : $clog2(MaxFrames + 1);

  localparam logic [CNT_W-1:0]   DbLast       = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FRAME_W-1:0] CooldownLoad = FRAME_W'(COOLDOWN_FRAMES);
`ifdef BUTTON_AUTOFIRE_EN
  localparam logic [FRAME_W-1:0] AutofireLoad = FRAME_W'(AUTOFIRE_FRAMES);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StCooldown,
    StWaitRelease
  } state_e;

  //--------------------------------------------------------------------------
  // Synchronisers
  //--------------------------------------------------------------------------
  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;

  assign raw = {fire_in, right_in, left_in};

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  //--------------------------------------------------------------------------
  // Debounce: counter runs only while the synchronised value differs from the
  // accepted state; any return to the accepted value discards the attempt.
  //--------------------------------------------------------------------------
  logic [NumBtn-1:0]            stable_q;
  logic [NumBtn-1:0]            stable_d;
  logic [NumBtn-1:0][CNT_W-1:0] db_cnt_q;
  logic [NumBtn-1:0][CNT_W-1:0] db_cnt_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < NumBtn; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  //--------------------------------------------------------------------------
  // Movement outputs: opposing directions cancel
  //--------------------------------------------------------------------------
  logic left_q;
  logic right_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= stable_q[BtnL] & ~stable_q[BtnR];
      right_q <= stable_q[BtnR] & ~stable_q[BtnL];
    end
  end

  assign left_out  = left_q;
  assign right_out = right_q;

  //--------------------------------------------------------------------------
  // Frame tick and fire press edge
  //--------------------------------------------------------------------------
  logic vsync_q;
  logic fire_prev_q;
  logic tick;
  logic fire_held;
  logic fire_rise;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_in;
      fire_prev_q <= stable_q[BtnF];
    end
  end

  assign tick      = vsync_in & ~vsync_q;
  assign fire_held = stable_q[BtnF];
  assign fire_rise = stable_q[BtnF] & ~fire_prev_q;

  //--------------------------------------------------------------------------
  // Fire FSM
  //--------------------------------------------------------------------------
  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  logic               pulse_q;
  logic               pulse_d;
`ifdef BUTTON_AUTOFIRE_EN
  // Set while the current FIRE/COOLDOWN round is an autofire repeat
  logic               repeat_q;
  logic               repeat_d;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      frame_q  <= '0;
      pulse_q  <= 1'b0;
`ifdef BUTTON_AUTOFIRE_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      pulse_q  <= pulse_d;
`ifdef BUTTON_AUTOFIRE_EN
      repeat_q <= repeat_d;
`endif
    end
  end

  // Next state. Presses seen outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fire_rise) state_d = StFire;
      end
      StFire: begin
        state_d = StCooldown;
      end
      StCooldown: begin
        if (frame_q == '0) begin
          if (fire_held) begin
`ifdef BUTTON_AUTOFIRE_EN
            state_d = StFire;
`else
            state_d = StWaitRelease;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitRelease: begin
        if (!fire_held) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame counter: load on FIRE takes precedence over a coincident tick;
  // decrement saturates at zero.
  always_comb begin
    frame_d = frame_q;
    if (state_q == StFire) begin
`ifdef BUTTON_AUTOFIRE_EN
      frame_d = repeat_q ? AutofireLoad : CooldownLoad;
`else
      frame_d = CooldownLoad;
`endif
    end else if ((state_q == StCooldown) && tick && (frame_q != '0)) begin
      frame_d = frame_q - 1'b1;
    end
  end

`ifdef BUTTON_AUTOFIRE_EN
  always_comb begin
    repeat_d = repeat_q;
    if ((state_q == StCooldown) && (state_d == StFire)) begin
      repeat_d = 1'b1;
    end else if (state_d == StIdle) begin
      repeat_d = 1'b0;
    end
  end
`endif

  // Outputs. The pulse is registered off the next state so it is high exactly
  // during the FIRE cycle.
  always_comb begin
    pulse_d    = (state_d == StFire);
    fire_ready = (state_q == StIdle);
  end

  assign fire_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2,
// AUTOFIRE_FRAMES=3. vsync has a 20-cycle period and is driven from the cycle counter.
// A frame tick is consumed at every edge whose cycle index is 1 mod 20.

module tb_button_conditioner;

  logic pclk = 1'b0;
  logic rst;
  logic left_in;
  logic right_in;
  logic fire_in;
  logic vsync_in;
  logic left_out;
  logic right_out;
  logic fire_pulse;
  logic fire_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int pulse_hi = 0;

  always #5 pclk = ~pclk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .COOLDOWN_FRAMES(2),
    .AUTOFIRE_FRAMES(3)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .left_in   (left_in),
    .right_in  (right_in),
    .fire_in   (fire_in),
    .vsync_in  (vsync_in),
    .left_out  (left_out),
    .right_out (right_out),
    .fire_pulse(fire_pulse),
    .fire_ready(fire_ready)
  );

  always @(negedge pclk) begin
    if (fire_pulse) pulse_hi <= pulse_hi + 1;
  end

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after each edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
      cycle++;
      vsync_in = ((cycle % 20) < 10);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Place the next press so that the FIRE cycle ends right after a frame tick
  task automatic align_frame();
    while ((cycle % 20) != 14) cyc(1);
  endtask

  int hi0;

  initial begin
    // 1. Reset with inputs high
    rst      = 1'b0;
    left_in  = 1'b1;
    right_in = 1'b1;
    fire_in  = 1'b1;
    vsync_in = 1'b0;
    cyc(3);
    check("rst_left", left_out, 1'b0);
    check("rst_right", right_out, 1'b0);
    check("rst_pulse", fire_pulse, 1'b0);
    right_in = 1'b0;
    fire_in  = 1'b0;
    rst      = 1'b1;
    cyc(1);
    check("rst_ready", fire_ready, 1'b1);
    cyc(5);
    check("rst_left_6", left_out, 1'b0);
    cyc(1);
    check("rst_left_7", left_out, 1'b1);
    check("rst_right_7", right_out, 1'b0);

    // 2. Bounce: high 3, low 1, then high
    left_in = 1'b0;
    cyc(10);
    check("bounce_pre", left_out, 1'b0);
    left_in = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      cyc(1);
      if (i == 3) left_in = 1'b0;
      if (i == 4) left_in = 1'b1;
      check("bounce_left", left_out, (i == 11));
    end

    // 3. Conflict
    right_in = 1'b1;
    cyc(6);
    check("conf_left_6", left_out, 1'b1);
    cyc(1);
    check("conf_left_7", left_out, 1'b0);
    check("conf_right_7", right_out, 1'b0);
    cyc(5);
    right_in = 1'b0;
    cyc(6);
    check("conf_rel_6", left_out, 1'b0);
    cyc(1);
    check("conf_rel_7", left_out, 1'b1);
    check("conf_rel_right", right_out, 1'b0);
    left_in  = 1'b0;
    right_in = 1'b1;
    cyc(6);
    check("swap_right_6", right_out, 1'b0);
    cyc(1);
    check("swap_right_7", right_out, 1'b1);
    check("swap_left_7", left_out, 1'b0);
    right_in = 1'b0;
    cyc(10);
    check("swap_right_off", right_out, 1'b0);

`ifndef BUTTON_AUTOFIRE_EN
    // 4. Single shot on a long hold
    check("ss_ready_pre", fire_ready, 1'b1);
    hi0     = pulse_hi;
    fire_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      check("ss_pulse", fire_pulse, (i == 7));
    end
    cyc(192);
    check_int("ss_pulse_count", pulse_hi - hi0, 1);
    check("ss_ready_held", fire_ready, 1'b0);
    fire_in = 1'b0;
    cyc(6);
    check("ss_ready_6", fire_ready, 1'b0);
    cyc(1);
    check("ss_ready_7", fire_ready, 1'b1);
`else
    // 6. Autofire: pulses at frame 0, frame 2, then every 3 frames; release mid-cooldown
    align_frame();
    hi0     = pulse_hi;
    fire_in = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      cyc(1);
      if (i == 190) fire_in = 1'b0;
      check("af_pulse", fire_pulse, (i == 7) || (i == 48) || (i == 108) || (i == 168));
    end
    check_int("af_pulse_count", pulse_hi - hi0, 4);
    check("af_ready_end", fire_ready, 1'b1);
`endif

    // 5. Cooldown drop
    align_frame();
    fire_in = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      cyc(1);
      if (i == 10) fire_in = 1'b0;
      if (i == 27) fire_in = 1'b1;
      if (i == 37) fire_in = 1'b0;
      if (i == 67) fire_in = 1'b1;
      if (i == 77) fire_in = 1'b0;
      check("cd_pulse", fire_pulse, (i == 7) || (i == 74));
      if (i == 40) check("cd_ready_40", fire_ready, 1'b0);
      if (i == 50) check("cd_ready_50", fire_ready, 1'b1);
    end
    cyc(60);
    check("cd_ready_end", fire_ready, 1'b1);

    // Reset while the pulse is high clears it asynchronously
    fire_in = 1'b1;
    cyc(7);
    check("rp_pulse_hi", fire_pulse, 1'b1);
    rst     = 1'b0;
    fire_in = 1'b0;
    #1;
    check("rp_pulse_cleared", fire_pulse, 1'b0);
    check("rp_ready", fire_ready, 1'b1);
    cyc(2);
    rst = 1'b1;
    cyc(10);

    // Reset mid-COOLDOWN returns to IDLE at once
    fire_in = 1'b1;
    cyc(20);
    check("rc_ready_cd", fire_ready, 1'b0);
    rst     = 1'b0;
    fire_in = 1'b0;
    #1;
    check("rc_ready_rst", fire_ready, 1'b1);
    check("rc_pulse_rst", fire_pulse, 1'b0);
    cyc(2);
    rst = 1'b1;
    cyc(10);
    check("rc_pulse_idle", fire_pulse, 1'b0);
    fire_in = 1'b1;
    cyc(7);
    check("rc_refire", fire_pulse, 1'b1);
    fire_in = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the game top level. It takes the raw left, right and fire push-buttons and produces clean signals for the ship-control path:
- debounced movement levels for left and right;
- a rate-limited, single-cycle missile fire pulse.

All logic is clocked on pclk. The block replaces the plain delay-line currently used on the controls.

Parameters:
DEBOUNCE_CYCLES, 650000, pclk cycles a synchronised input must hold a new value before it is accepted (10 ms at 65 MHz).
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
COOLDOWN_FRAMES, 8, minimum frames between two fire pulses.
AUTOFIRE_FRAMES, 15, repeat period in frames while fire is held (AUTOFIRE_EN only).

Ports:
pclk  input  1  pixel clock, 65 MHz
rst  input  1  asynchronous, active-low reset
left_in  input  1  raw left button, asynchronous
right_in  input  1  raw right button, asynchronous
fire_in  input  1  raw missile button, asynchronous
vsync_in  input  1  vsync from the timing chain; its rising edge is the frame tick
left_out  output  1  debounced left level, registered
right_out  output  1  debounced right level, registered
fire_pulse  output  1  one-pclk missile request, registered
fire_ready  output  1  high when a new press would fire (FSM in IDLE)

Behaviour:
- Reset: rst low asynchronously clears all of the following:
  - synchronisers, debounce counters and stable states;
  - the vsync edge register and the frame counter;
  - outputs left_out=0, right_out=0, fire_pulse=0.
  - FSM goes to IDLE, so fire_ready=1 from the first clock after reset release.
- Synchronisation: each raw input passes through 2 flops.
- Debounce, per button:
  - If the synchronised value equals the stable state, the counter clears.
  - Otherwise the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing, the stable state takes the new value and the counter clears.
  - Any glitch back to the stable value before that cycle clears the counter and the transition is discarded.
  - Latency from an input edge to the output edge is 2 + DEBOUNCE_CYCLES + 1 pclk.
- Movement conflict:
  - left_out = stable_left & ~stable_right.
  - right_out = stable_right & ~stable_left.
  - Both pressed drives both outputs to 0. Releasing one restores the other on the next cycle.
- Frame tick: vsync_in is registered. tick = vsync_in & ~vsync_q, a one-cycle pulse.
- Fire FSM (states IDLE, FIRE, COOLDOWN, WAIT_RELEASE):
  - IDLE: a rising edge of the stable fire state moves to FIRE.
  - FIRE: fire_pulse=1 for exactly this cycle. Load frame counter = COOLDOWN_FRAMES, go to COOLDOWN.
  - COOLDOWN: the frame counter decrements by 1 on each tick. When it reaches 0, go to WAIT_RELEASE if fire is still stable-high, otherwise IDLE.
  - WAIT_RELEASE: stay until stable fire=0, then go to IDLE.
- Press edges arriving in COOLDOWN or WAIT_RELEASE are dropped, not queued.
- A tick coincident with the FIRE cycle does not decrement the counter; the load wins.
- COOLDOWN_FRAMES=0: COOLDOWN exits on its first cycle.
- fire_ready = (state==IDLE).
- The frame counter saturates at 0 and never wraps.

Optional Feature:
Macro BUTTON_AUTOFIRE_EN.
- Defined: when COOLDOWN ends with fire still held, the FSM returns to FIRE instead of WAIT_RELEASE. That repeat reloads the counter with AUTOFIRE_FRAMES, so holding fire produces a pulse every AUTOFIRE_FRAMES frames. Releasing fire behaves as in the base design.
- Undefined: exactly one pulse per press, as described above.

Test Plan:
Use DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2, AUTOFIRE_FRAMES=3, and vsync with a 20-cycle period.
1. Reset: hold rst=0 with all inputs at 1 -> outputs 0, fire_ready=1 after release. Inputs held 1 -> left_out rises exactly 7 cycles after release.
2. Bounce: left_in toggles high 3 cycles, low 1 cycle, high 10 cycles -> left_out rises 7 cycles after the final rising edge only, with no earlier glitch.
3. Conflict: left and right both stable high -> both outputs 0. Drop right -> left_out=1 one cycle after right's stable state falls.
4. Single shot: press fire and hold 200 cycles -> exactly one fire_pulse, 1 cycle wide. fire_ready returns to 1 only after release.
5. Cooldown drop: second press 1 frame after the first pulse -> no pulse. A press 3 frames later -> a pulse.
6. Autofire (BUTTON_AUTOFIRE_EN): hold fire for 10 frames -> pulses at frame 0, then frame 2, then every 3 frames. Release mid-cooldown -> no further pulse. Assert rst=0 mid-COOLDOWN -> fire_pulse=0 immediately and FSM in IDLE.
